// File: rtl/regfile_wb_arbiter_if.sv
// ---------------------------------------------------------------------------
// regfile_wb_arbiter_if
//   Bundles the two writeback request channels and the issue/hazard channel
//   that sit in front of the register-file controller.
//
//   Writeback channel X (X = 0 ALU, 1 LSU):
//     wbX_valid  request present        wbX_addr  destination register
//     wbX_data   value to write         wbX_ready request accepted this cycle
//   Issue channel:
//     iss_valid  instruction presented  iss_rd1_en/iss_rd1, iss_rd2_en/iss_rd2
//     iss_dst_en/iss_dst  destination   iss_stall  decode must hold
//
//   Modports: master = requesters/decode, slave = controller.
// ---------------------------------------------------------------------------
interface regfile_wb_arbiter_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4
);
    logic              wb0_valid;
    logic [ADDR_W-1:0] wb0_addr;
    logic [DATA_W-1:0] wb0_data;
    logic              wb0_ready;

    logic              wb1_valid;
    logic [ADDR_W-1:0] wb1_addr;
    logic [DATA_W-1:0] wb1_data;
    logic              wb1_ready;

    logic              iss_valid;
    logic              iss_rd1_en;
    logic [ADDR_W-1:0] iss_rd1;
    logic              iss_rd2_en;
    logic [ADDR_W-1:0] iss_rd2;
    logic              iss_dst_en;
    logic [ADDR_W-1:0] iss_dst;
    logic              iss_stall;

    modport master (
        output wb0_valid, wb0_addr, wb0_data,
        output wb1_valid, wb1_addr, wb1_data,
        output iss_valid, iss_rd1_en, iss_rd1, iss_rd2_en, iss_rd2, iss_dst_en, iss_dst,
        input  wb0_ready, wb1_ready, iss_stall
    );

    modport slave (
        input  wb0_valid, wb0_addr, wb0_data,
        input  wb1_valid, wb1_addr, wb1_data,
        input  iss_valid, iss_rd1_en, iss_rd1, iss_rd2_en, iss_rd2, iss_dst_en, iss_dst,
        output wb0_ready, wb1_ready, iss_stall
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// ---------------------------------------------------------------------------
// regfile_wb_arbiter
//   Controller in front of a two-read/one-write register file. Shares the
//   single write port between the ALU (req0) and LSU (req1) writeback
//   channels with round-robin arbitration, registers the winning write for
//   one cycle, tracks outstanding destination registers in a busy-bit
//   scoreboard and stalls issue on RAW/WAW hazards.
//
//   Ports:
//     clk, reset_n        clock, asynchronous active-low reset
//     bus                 writeback + issue channels (slave modport)
//     rf_rdata1/2         register-file read data
//     op1, op2            operands to execute
//     rf_ctrl             [0] we, [ADDR_W:1] waddr, [2*ADDR_W:ADDR_W+1] raddr1,
//                         [3*ADDR_W:2*ADDR_W+1] raddr2
//     rf_wdata            register-file write data
//     busy                scoreboard bits (debug)
//
//   Optional: define REGFILE_WB_BYPASS_EN to forward the pending write to
//   the operands and drop the matching RAW stall terms.
// ---------------------------------------------------------------------------
module regfile_wb_arbiter #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4
) (
    input  logic                    clk,
    input  logic                    reset_n,
    regfile_wb_arbiter_if.slave     bus,
    input  logic [DATA_W-1:0]       rf_rdata1,
    input  logic [DATA_W-1:0]       rf_rdata2,
    output logic [DATA_W-1:0]       op1,
    output logic [DATA_W-1:0]       op2,
    output logic [3*ADDR_W:0]       rf_ctrl,
    output logic [DATA_W-1:0]       rf_wdata,
    output logic [2**ADDR_W-1:0]    busy
);
    localparam int NREG = 2**ADDR_W;

    // Round-robin preference: which requester wins when both are valid.
    typedef enum logic {
        PREF_REQ0 = 1'b0,
        PREF_REQ1 = 1'b1
    } rr_e;

    rr_e rr_q, rr_d;
    logic grant0, grant1;

    // NOTE: every combinational output gets a default before any branch, so
    // no path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        rr_d   = rr_q;
        if (bus.wb0_valid && bus.wb1_valid) begin
            if (rr_q == PREF_REQ0) begin
                grant0 = 1'b1;
                rr_d   = PREF_REQ1;
            end else begin
                grant1 = 1'b1;
                rr_d   = PREF_REQ0;
            end
        end else if (bus.wb0_valid) begin
            grant0 = 1'b1;
            rr_d   = PREF_REQ1;
        end else if (bus.wb1_valid) begin
            grant1 = 1'b1;
            rr_d   = PREF_REQ0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) rr_q <= PREF_REQ0;
        else          rr_q <= rr_d;
    end

    // Readies are forced low while reset is asserted even if requests are up.
    assign bus.wb0_ready = grant0 & reset_n;
    assign bus.wb1_ready = grant1 & reset_n;

    // -----------------------------------------------------------------------
    // Write stage: the accepted request is presented to the register file for
    // exactly one cycle. Data holds its last value when nothing is written.
    // -----------------------------------------------------------------------
    logic              we_q;
    logic [ADDR_W-1:0] waddr_q;
    logic [DATA_W-1:0] wdata_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else begin
            we_q <= grant0 | grant1;
            if (grant0) begin
                waddr_q <= bus.wb0_addr;
                wdata_q <= bus.wb0_data;
            end else if (grant1) begin
                waddr_q <= bus.wb1_addr;
                wdata_q <= bus.wb1_data;
            end
        end
    end

    assign rf_ctrl  = {bus.iss_rd2, bus.iss_rd1, waddr_q, we_q};
    assign rf_wdata = wdata_q;

    // -----------------------------------------------------------------------
    // Hazard detection and operand selection
    // -----------------------------------------------------------------------
    logic [NREG-1:0] busy_q, busy_d;
    logic raw1, raw2, waw;

    assign raw1 = bus.iss_rd1_en & busy_q[bus.iss_rd1];
    assign raw2 = bus.iss_rd2_en & busy_q[bus.iss_rd2];
    assign waw  = bus.iss_dst_en & busy_q[bus.iss_dst];

`ifdef REGFILE_WB_BYPASS_EN
    // The pending write lands at the coming edge; a reader of that register
    // can take the value straight from the write stage instead of stalling.
    logic fwd1, fwd2;

    assign fwd1 = we_q & bus.iss_rd1_en & (waddr_q == bus.iss_rd1);
    assign fwd2 = we_q & bus.iss_rd2_en & (waddr_q == bus.iss_rd2);

    assign op1 = fwd1 ? wdata_q : rf_rdata1;
    assign op2 = fwd2 ? wdata_q : rf_rdata2;

    assign bus.iss_stall = bus.iss_valid & ((raw1 & ~fwd1) | (raw2 & ~fwd2) | waw);
`else
    assign op1 = rf_rdata1;
    assign op2 = rf_rdata2;

    assign bus.iss_stall = bus.iss_valid & (raw1 | raw2 | waw);
`endif

    // -----------------------------------------------------------------------
    // Scoreboard. The clear for the landing write is applied before the set
    // from issue, so a same-register set and clear on one edge leaves it set.
    // A write to a register that is not busy simply clears an already-clear bit.
    // -----------------------------------------------------------------------
    logic issue_fire;

    assign issue_fire = bus.iss_valid & bus.iss_dst_en & ~bus.iss_stall;

    always_comb begin
        busy_d = busy_q;
        if (we_q)       busy_d[waddr_q]     = 1'b0;
        if (issue_fire) busy_d[bus.iss_dst] = 1'b1;
    end

    // NOTE: the busy array is a handful of flops, not a RAM, so it is reset
    // along with the rest of the control state; reset drops every in-flight
    // producer together with the pending write.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) busy_q <= '0;
        else          busy_q <= busy_d;
    end

    assign busy = busy_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// ---------------------------------------------------------------------------
// tb_regfile_wb_arbiter
//   Self-checking bench for regfile_wb_arbiter. Directed sequences followed
//   by randomized traffic; expected writes are queued by a reference model
//   and consumed by an independent monitor. Honours REGFILE_WB_BYPASS_EN.
// ---------------------------------------------------------------------------
module tb_regfile_wb_arbiter;

`ifdef REGFILE_WB_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n;
    logic [15:0] rf_rdata1, rf_rdata2;
    logic [15:0] op1, op2, rf_wdata, busy;
    logic [12:0] rf_ctrl;

    regfile_wb_arbiter_if #(.DATA_W(16), .ADDR_W(4)) bus_if ();

    regfile_wb_arbiter #(.DATA_W(16), .ADDR_W(4)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .bus       (bus_if),
        .rf_rdata1 (rf_rdata1),
        .rf_rdata2 (rf_rdata2),
        .op1       (op1),
        .op2       (op2),
        .rf_ctrl   (rf_ctrl),
        .rf_wdata  (rf_wdata),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [3:0]  addr;
        logic [15:0] data;
    } wr_t;

    wr_t         exp_q[$];
    int          m_last_winner;   // requester granted most recently (1 => req0 preferred)
    bit [15:0]   m_busy;          // registers with an outstanding producer
    bit          m_we;            // a write is being presented this cycle
    bit [3:0]    m_waddr;
    bit [15:0]   m_wdata;
    bit          last_g0, last_g1, last_stall;

    task automatic model_reset();
        m_last_winner = 1;
        m_busy        = '0;
        m_we          = 1'b0;
        m_waddr       = '0;
        m_wdata       = '0;
        last_g0       = 1'b0;
        last_g1       = 1'b0;
        last_stall    = 1'b0;
        exp_q.delete();
    endtask

    // Does a read of register r have to wait this cycle?
    function automatic bit read_blocked(input bit en, input logic [3:0] r);
        if (!en || !m_busy[r]) return 1'b0;
        if (BYPASS && m_we && m_waddr == r) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [15:0] exp_operand(input bit en, input logic [3:0] r, input logic [15:0] rf);
        if (BYPASS && en && m_we && m_waddr == r) return m_wdata;
        return rf;
    endfunction

    // Called mid-cycle: compare every visible output against the model, then
    // advance the model to the state it will hold after the coming edge.
    task automatic model_cycle();
        bit v0, v1, g0, g1, stall;
        int winner;
        v0 = bus_if.wb0_valid;
        v1 = bus_if.wb1_valid;
        winner = -1;
        if (v0 && v1)  winner = (m_last_winner == 0) ? 1 : 0;
        else if (v0)   winner = 0;
        else if (v1)   winner = 1;
        g0 = (winner == 0);
        g1 = (winner == 1);

        stall = bus_if.iss_valid &&
                (read_blocked(bus_if.iss_rd1_en, bus_if.iss_rd1) ||
                 read_blocked(bus_if.iss_rd2_en, bus_if.iss_rd2) ||
                 (bus_if.iss_dst_en && m_busy[bus_if.iss_dst]));

        check("wb0_ready", 32'(bus_if.wb0_ready), 32'(g0));
        check("wb1_ready", 32'(bus_if.wb1_ready), 32'(g1));
        check("one_ready", 32'(bus_if.wb0_ready & bus_if.wb1_ready), 32'd0);
        check("rf_we", 32'(rf_ctrl[0]), 32'(m_we));
        if (m_we) check("rf_waddr", 32'(rf_ctrl[4:1]), 32'(m_waddr));
        check("rf_wdata", 32'(rf_wdata), 32'(m_wdata));
        check("rf_raddr", 32'(rf_ctrl[12:5]), 32'({bus_if.iss_rd2, bus_if.iss_rd1}));
        check("busy", 32'(busy), 32'(m_busy));
        check("iss_stall", 32'(bus_if.iss_stall), 32'(stall));
        check("op1", 32'(op1), 32'(exp_operand(bus_if.iss_rd1_en, bus_if.iss_rd1, rf_rdata1)));
        check("op2", 32'(op2), 32'(exp_operand(bus_if.iss_rd2_en, bus_if.iss_rd2, rf_rdata2)));

        // Landing write clears first, then an accepted issue sets (set wins).
        if (m_we) m_busy[m_waddr] = 1'b0;
        if (bus_if.iss_valid && bus_if.iss_dst_en && !stall) m_busy[bus_if.iss_dst] = 1'b1;

        m_we = (winner >= 0);
        if (winner == 0) begin
            m_waddr = bus_if.wb0_addr;
            m_wdata = bus_if.wb0_data;
        end else if (winner == 1) begin
            m_waddr = bus_if.wb1_addr;
            m_wdata = bus_if.wb1_data;
        end
        if (winner >= 0) begin
            m_last_winner = winner;
            exp_q.push_back('{addr: m_waddr, data: m_wdata});
        end
        last_g0    = g0;
        last_g1    = g1;
        last_stall = stall;
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (reset_n === 1'b1 && rf_ctrl[0] === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("wr_unexpected", 32'(rf_ctrl[0]), 32'd0);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("mon_waddr", 32'(rf_ctrl[4:1]), 32'(e.addr));
                check("mon_wdata", 32'(rf_wdata), 32'(e.data));
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(negedge clk);
        model_cycle();
        @(posedge clk);
        #1;
        rf_rdata1 = 16'($urandom);
        rf_rdata2 = 16'($urandom);
    endtask

    task automatic idle_inputs();
        bus_if.wb0_valid  = 1'b0; bus_if.wb0_addr = '0; bus_if.wb0_data = '0;
        bus_if.wb1_valid  = 1'b0; bus_if.wb1_addr = '0; bus_if.wb1_data = '0;
        bus_if.iss_valid  = 1'b0;
        bus_if.iss_rd1_en = 1'b0; bus_if.iss_rd1  = '0;
        bus_if.iss_rd2_en = 1'b0; bus_if.iss_rd2  = '0;
        bus_if.iss_dst_en = 1'b0; bus_if.iss_dst  = '0;
    endtask

    task automatic wb0(input bit v, input logic [3:0] a, input logic [15:0] d);
        bus_if.wb0_valid = v; bus_if.wb0_addr = a; bus_if.wb0_data = d;
    endtask

    task automatic wb1(input bit v, input logic [3:0] a, input logic [15:0] d);
        bus_if.wb1_valid = v; bus_if.wb1_addr = a; bus_if.wb1_data = d;
    endtask

    task automatic iss(input bit v, input bit r1e, input logic [3:0] r1,
                       input bit r2e, input logic [3:0] r2, input bit de, input logic [3:0] dst);
        bus_if.iss_valid  = v;
        bus_if.iss_rd1_en = r1e; bus_if.iss_rd1 = r1;
        bus_if.iss_rd2_en = r2e; bus_if.iss_rd2 = r2;
        bus_if.iss_dst_en = de;  bus_if.iss_dst = dst;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        idle_inputs();
        model_reset();
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        reset_n   = 1'b1;
        rf_rdata1 = 16'h0;
        rf_rdata2 = 16'h0;
        idle_inputs();
        model_reset();
        #1 reset_n = 1'b0;

        // Reset state, with both requests raised to show readies stay low.
        wb0(1'b1, 4'd6, 16'h5555);
        wb1(1'b1, 4'd7, 16'h6666);
        @(negedge clk);
        check("rst_ctrl_low", 32'(rf_ctrl[4:0]), 32'd0);
        check("rst_wdata", 32'(rf_wdata), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ready0", 32'(bus_if.wb0_ready), 32'd0);
        check("rst_ready1", 32'(bus_if.wb1_ready), 32'd0);
        idle_inputs();
        @(posedge clk);
        #1 reset_n = 1'b1;

        // Single ALU write to r3.
        wb0(1'b1, 4'd3, 16'h1234);
        tick();
        wb0(1'b0, 4'd0, 16'h0);
        @(negedge clk);
        check("single_ctrl", 32'(rf_ctrl[4:0]), 32'b00111);
        check("single_wdata", 32'(rf_wdata), 32'h1234);
        model_cycle();
        @(posedge clk); #1;
        tick();

        // Both requesters for four cycles from a fresh pointer.
        do_reset();
        wb0(1'b1, 4'd1, 16'hA001);
        wb1(1'b1, 4'd2, 16'hB002);
        repeat (4) tick();
        wb0(1'b0, 4'd0, 16'h0);
        wb1(1'b0, 4'd0, 16'h0);
        repeat (2) tick();

        // RAW: dst=5, then read r5 until writeback lands.
        iss(1'b1, 1'b0, 4'd0, 1'b0, 4'd0, 1'b1, 4'd5);
        tick();
        iss(1'b1, 1'b1, 4'd5, 1'b0, 4'd0, 1'b0, 4'd0);
        repeat (3) tick();
        wb0(1'b1, 4'd5, 16'h0505);
        tick();
        wb0(1'b0, 4'd0, 16'h0);
        repeat (3) tick();
        check("busy5_clear", 32'(busy[5]), 32'd0);
        iss(1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0);

        // WAW: dst=7 twice; second waits for the writeback.
        iss(1'b1, 1'b0, 4'd0, 1'b0, 4'd0, 1'b1, 4'd7);
        repeat (3) tick();
        wb1(1'b1, 4'd7, 16'h0707);
        tick();
        wb1(1'b0, 4'd0, 16'h0);
        repeat (3) tick();
        iss(1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0);
        wb0(1'b1, 4'd7, 16'h7777);
        tick();
        wb0(1'b0, 4'd0, 16'h0);
        repeat (2) tick();

        // Set and clear of r9 on the same edge.
        wb0(1'b1, 4'd9, 16'h0909);
        tick();
        wb0(1'b0, 4'd0, 16'h0);
        iss(1'b1, 1'b0, 4'd0, 1'b0, 4'd0, 1'b1, 4'd9);
        tick();
        iss(1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0);
        @(negedge clk);
        check("busy9_set_wins", 32'(busy[9]), 32'd1);
        model_cycle();
        @(posedge clk); #1;
        wb1(1'b1, 4'd9, 16'h9999);
        tick();
        wb1(1'b0, 4'd0, 16'h0);
        repeat (2) tick();

        // Pending write to r4 while a reader of r4 issues.
        iss(1'b1, 1'b0, 4'd0, 1'b0, 4'd0, 1'b1, 4'd4);
        tick();
        iss(1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0);
        wb0(1'b1, 4'd4, 16'hBEEF);
        tick();
        wb0(1'b0, 4'd0, 16'h0);
        iss(1'b1, 1'b0, 4'd0, 1'b1, 4'd4, 1'b0, 4'd0);
        rf_rdata2 = 16'h0000;
        @(negedge clk);
        check("bypass_stall", 32'(bus_if.iss_stall), BYPASS ? 32'd0 : 32'd1);
        check("bypass_op2", 32'(op2), BYPASS ? 32'hBEEF : 32'h0000);
        model_cycle();
        @(posedge clk); #1;
        repeat (2) tick();
        iss(1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0);
        tick();

        // Fill the scoreboard, leave a write pending, then reset mid-cycle.
        do_reset();
        for (int r = 0; r < 16; r++) begin
            iss(1'b1, 1'b0, 4'd0, 1'b0, 4'd0, 1'b1, 4'(r));
            tick();
        end
        iss(1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0);
        wb0(1'b1, 4'd3, 16'hC0DE);
        wb1(1'b1, 4'd8, 16'hD00D);
        tick();
        check("full_busy", 32'(busy), 32'hFFFF);
        check("pending_we", 32'(rf_ctrl[0]), 32'd1);
        #1 reset_n = 1'b0;
        #1;
        check("midrst_we", 32'(rf_ctrl[0]), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_ready0", 32'(bus_if.wb0_ready), 32'd0);
        check("midrst_ready1", 32'(bus_if.wb1_ready), 32'd0);
        do_reset();

        // Randomized traffic; requesters and decode hold until accepted.
        for (int n = 0; n < 400; n++) begin
            if (!bus_if.wb0_valid || last_g0)
                wb0(($urandom_range(0, 99) < 60), 4'($urandom), 16'($urandom));
            if (!bus_if.wb1_valid || last_g1)
                wb1(($urandom_range(0, 99) < 60), 4'($urandom), 16'($urandom));
            if (!bus_if.iss_valid || !last_stall)
                iss(($urandom_range(0, 99) < 50), 1'($urandom), 4'($urandom),
                    1'($urandom), 4'($urandom), 1'($urandom), 4'($urandom));
            tick();
        end
        idle_inputs();
        repeat (3) tick();
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
